logic_clk_div_multi: RTL
========================

Name: logic_clk_div_multi

Overview:
Parametrised successor of the single-channel logic clock divider. Generates NUM_CH independent divided clocks from one master clock. Each channel has programmable period, high time and phase. Config is double-buffered, so updates apply only at period boundaries and never glitch. Sits behind the block's AXI4-Lite register bank, which drives the cfg_* inputs and samples the status outputs.

Parameters:
NUM_CH, 4, number of output channels (1..16)
COUNTER_BITS, 32, width of per-channel period/high/phase counters

Ports:
master_clk  in  1  sole clock; all logic on rising edge
master_resetn  in  1  reset, synchronous, active-low
ch_en  in  NUM_CH  per-channel run enable (level)
cfg_period  in  NUM_CH*COUNTER_BITS  period in master_clk cycles; channel i at [i*COUNTER_BITS +: COUNTER_BITS]
cfg_high  in  NUM_CH*COUNTER_BITS  high cycles per period
cfg_phase  in  NUM_CH*COUNTER_BITS  start offset, in counter cycles
cfg_update  in  NUM_CH  1-cycle pulse: mark channel's new config pending
sync_start  in  1  1-cycle pulse: restart all enabled channels aligned
clk_out  out  NUM_CH  divided clocks (registered)
period_tick  out  NUM_CH  1-cycle pulse on last cycle of each period
ch_active  out  NUM_CH  channel running
cfg_err  out  NUM_CH  sticky: illegal config seen at last shadow load

Behaviour:
- Reset: clk_out, period_tick, ch_active, cfg_err, counters, shadows and pending flags all 0.
- Per-channel state machine: IDLE -> RUN -> STOPPING -> IDLE.
- IDLE:
  - ch_en=1 or sync_start with ch_en=1: load shadow period/high/phase from cfg_*; cnt <= phase_sh; go to RUN.
  - cfg_err is recomputed on every shadow load.
- Shadow legality:
  - period_sh < 2: cfg_err=1; channel stays IDLE; clk_out=0.
  - high_sh > period_sh-1: clamp to period_sh-1, so at least one low cycle per period.
  - phase_sh >= period_sh: use 0 and set cfg_err=1; channel still runs.
- RUN:
  - cnt increments; wraps from period_sh-1 to 0.
  - clk_out <= (cnt < high_sh); one-cycle latency from cnt to pin.
  - high_sh=0: clk_out stays 0 and period_tick still pulses.
  - period_tick <= (cnt == period_sh-1), same latency as clk_out.
- Update at boundary:
  - cfg_update[i] sets pending[i].
  - When a RUN channel wraps with pending set: reload shadows from current cfg_*, clear pending, continue.
  - New phase is ignored on reload (count restarts at 0).
  - cfg_update in IDLE is a no-op.
- Stop: ch_en falls in RUN -> STOPPING. Counting continues until wrap, then IDLE with clk_out=0. The final period is never truncated.
- ch_en rises again during STOPPING: return to RUN, no restart.
- ch_active = 1 in RUN and STOPPING.
- sync_start:
  - Every channel in RUN/STOPPING with ch_en=1 reloads shadows and sets cnt <= phase_sh on the same edge, ignoring pending boundaries.
  - Enabled IDLE channels start on that same edge.
  - Deliberate restart; may truncate one period.
- sync_start has priority over a simultaneous wrap reload. cfg_update on the same cycle as sync_start is absorbed; pending cleared.
- master_resetn=0 mid-operation: all outputs 0 on the next edge; state IDLE.
- Widths: compare/increment at COUNTER_BITS, no overflow; period up to 2^COUNTER_BITS-1.

Optional Feature:
LOGIC_CLK_DIV_MULTI_INVERT_EN
- Defined: adds input port cfg_invert [NUM_CH]. It is shadowed with the other config, i.e. loaded on start, boundary reload and sync_start.
- A channel with invert_sh=1 drives clk_out = ~(cnt < high_sh) while RUN/STOPPING.
- Outputs are still 0 in IDLE and reset. period_tick is unaffected.
- Undefined: no port; no inversion logic.

Test Plan:
- ch0 period=4, high=2, phase=0, ch_en=1 -> clk_out[0] = 1100 repeating, first 1 two cycles after the ch_en edge; period_tick every 4th cycle, aligned with last low.
- ch0 and ch1 period=6, high=3; ch1 phase=3; sync_start -> clk_out[1] is clk_out[0] shifted by 3 cycles (180°); both edges aligned to the sync_start edge.
- ch0 running period=4, set cfg_period=10, high=5, pulse cfg_update mid-period -> current 4-cycle period completes intact, then 5 high/5 low; no short pulse.
- Drop ch_en at cnt=1 with period=8, high=4 -> clk_out completes 1111 0000, then stays 0; ch_active falls at wrap.
- period=1 -> cfg_err=1, ch_active=0, clk_out=0. period=5, high=9 -> high clamped to 4 (11110). phase=7 with period=5 -> cfg_err=1, starts at cnt 0.
- Assert master_resetn=0 for 1 cycle while 3 channels run -> all outputs 0 next edge. With ch_en held, channels restart from phase on release.

Source files
------------

// File: rtl/logic_clk_div_multi.sv
// ============================================================================
// Module  : logic_clk_div_multi
// Brief   : NUM_CH independent programmable clock dividers with double-buffered
//           period/high/phase config, boundary-aligned updates and sync restart.
//           Optional macro LOGIC_CLK_DIV_MULTI_INVERT_EN adds per-channel output
//           inversion (cfg_invert), shadowed with the rest of the config.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_clk_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int COUNTER_BITS = 32
) (
  input  logic                           master_clk,
  input  logic                           master_resetn,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH*COUNTER_BITS-1:0] cfg_period,
  input  logic [NUM_CH*COUNTER_BITS-1:0] cfg_high,
  input  logic [NUM_CH*COUNTER_BITS-1:0] cfg_phase,
  input  logic [NUM_CH-1:0]              cfg_update,
`ifdef LOGIC_CLK_DIV_MULTI_INVERT_EN
  input  logic [NUM_CH-1:0]              cfg_invert,
`endif
  input  logic                           sync_start,
  output logic [NUM_CH-1:0]              clk_out,
  output logic [NUM_CH-1:0]              period_tick,
  output logic [NUM_CH-1:0]              ch_active,
  output logic [NUM_CH-1:0]              cfg_err
);

  localparam logic [COUNTER_BITS-1:0] c_ZERO = '0;
  localparam logic [COUNTER_BITS-1:0] c_ONE  = COUNTER_BITS'(1);
  localparam logic [COUNTER_BITS-1:0] c_TWO  = COUNTER_BITS'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [COUNTER_BITS-1:0] w_p;
    logic [COUNTER_BITS-1:0] w_h;
    logic [COUNTER_BITS-1:0] w_ph;
    logic [COUNTER_BITS-1:0] w_h_clamp;
    logic [COUNTER_BITS-1:0] w_start;
    logic                    w_bad_period;
    logic                    w_bad_phase;
    logic                    w_last;
    logic                    w_lt;
    logic                    w_wave;
    logic                    w_do_start;

    state_t                  r_state;
    logic [COUNTER_BITS-1:0] r_cnt;
    logic [COUNTER_BITS-1:0] r_period_sh;
    logic [COUNTER_BITS-1:0] r_high_sh;
    logic                    r_clk;
    logic                    r_tick;
    logic                    r_err;
    logic                    r_pending;

    assign w_p  = cfg_period[i*COUNTER_BITS +: COUNTER_BITS];
    assign w_h  = cfg_high[i*COUNTER_BITS +: COUNTER_BITS];
    assign w_ph = cfg_phase[i*COUNTER_BITS +: COUNTER_BITS];

    // Legality of the live config as it would be captured into the shadows.
    assign w_bad_period = (w_p < c_TWO);
    assign w_bad_phase  = (w_ph >= w_p);
    assign w_h_clamp    = (w_h > (w_p - c_ONE)) ? (w_p - c_ONE) : w_h;
    assign w_start      = w_bad_phase ? c_ZERO : w_ph;

    assign w_last = (r_cnt == (r_period_sh - c_ONE));
    assign w_lt   = (r_cnt < r_high_sh);

    // A full start (with phase) happens from IDLE or on a sync restart.
    assign w_do_start = ch_en[i] & (sync_start | (r_state == ST_IDLE));

`ifdef LOGIC_CLK_DIV_MULTI_INVERT_EN
    logic r_inv_sh;
    assign w_wave = w_lt ^ r_inv_sh;
`else
    assign w_wave = w_lt;
`endif

    always_ff @(posedge master_clk) begin
      if (!master_resetn) begin
        r_state     <= ST_IDLE;
        r_cnt       <= c_ZERO;
        r_period_sh <= c_ZERO;
        r_high_sh   <= c_ZERO;
        r_clk       <= 1'b0;
        r_tick      <= 1'b0;
        r_err       <= 1'b0;
        r_pending   <= 1'b0;
`ifdef LOGIC_CLK_DIV_MULTI_INVERT_EN
        r_inv_sh    <= 1'b0;
`endif
      end else if (w_do_start) begin
        r_period_sh <= w_p;
        r_high_sh   <= w_h_clamp;
`ifdef LOGIC_CLK_DIV_MULTI_INVERT_EN
        r_inv_sh    <= cfg_invert[i];
`endif
        r_err       <= w_bad_period | w_bad_phase;
        r_pending   <= 1'b0;
        r_clk       <= 1'b0;
        r_tick      <= 1'b0;
        if (w_bad_period) begin
          r_state <= ST_IDLE;
          r_cnt   <= c_ZERO;
        end else begin
          r_state <= ST_RUN;
          r_cnt   <= w_start;
        end
      end else begin
        case (r_state)
          ST_RUN, ST_STOP: begin
            r_clk  <= w_wave;
            r_tick <= w_last;
            if (cfg_update[i]) begin
              r_pending <= 1'b1;
            end
            if (w_last) begin
              r_cnt <= c_ZERO;
              if (!ch_en[i]) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_RUN;
                // Boundary reload keeps the count at 0; new phase is not applied.
                if (r_pending) begin
                  r_period_sh <= w_p;
                  r_high_sh   <= w_h_clamp;
`ifdef LOGIC_CLK_DIV_MULTI_INVERT_EN
                  r_inv_sh    <= cfg_invert[i];
`endif
                  r_err       <= w_bad_period;
                  r_pending   <= 1'b0;
                  if (w_bad_period) begin
                    r_state <= ST_IDLE;
                  end
                end
              end
            end else begin
              r_cnt   <= r_cnt + c_ONE;
              r_state <= ch_en[i] ? ST_RUN : ST_STOP;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
          end
        endcase
      end
    end

    assign clk_out[i]     = r_clk;
    assign period_tick[i] = r_tick;
    assign ch_active[i]   = (r_state != ST_IDLE);
    assign cfg_err[i]     = r_err;
  end : g_ch

endmodule

`default_nettype wire
